// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the HI/LO multiply/divide controller.
//   DW         operand width (HI and LO are DW bits each)
//   OP_*       op encodings presented by the EX stage
//   state_t    controller state
//   is_muldiv  op is an iterating MULT/MULTU/DIV/DIVU
//   is_div     op is DIV/DIVU
`timescale 1ns/1ps
package mdu_pkg;

    localparam int DW = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Encodings 0..3 are the iterating ops.
    function automatic logic is_muldiv(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> controller bundle.
//   master (EX side): drives op_valid, op, src_a, src_b, flush
//   slave  (mdu)    : drives stall_req, busy, we_hi/we_lo, wb_hi/wb_lo, div_by_zero
`timescale 1ns/1ps
interface mdu_if #(parameter int W = mdu_pkg::DW);
    logic          op_valid;
    logic [2:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          flush;
    logic          stall_req;
    logic          busy;
    logic          we_hi;
    logic          we_lo;
    logic [W-1:0]  wb_hi;
    logic [W-1:0]  wb_lo;
    logic          div_by_zero;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  stall_req, busy, we_hi, we_lo, wb_hi, wb_lo, div_by_zero
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output stall_req, busy, we_hi, we_lo, wb_hi, wb_lo, div_by_zero
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: shared 2W-bit {hi,lo} accumulator for unsigned multiply/divide.
//   start     load operands (a, b) and mode; hi cleared
//   step      commit one iteration into the accumulator
//   div_mode  0: shift-add multiply a*b, 1: restoring divide a/b
//   raw       accumulator value after the current iteration (combinational),
//             so the controller can capture the final result on the last step
// Multiply: lo holds the multiplier, result shifts right into {hi,lo}.
// Divide:   lo holds the dividend, quotient bits shift in at lo[0], hi is remainder.
`timescale 1ns/1ps
module mdu_iter #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           step,
    input  logic           div_mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] raw
);

    logic [W-1:0] hi, lo, opnd;
    logic         mode_q;

    logic [W:0]     sum;
    logic [W:0]     rem_sh;
    logic           ge;
    logic [W-1:0]   rem_n;
    logic [2*W-1:0] mul_nxt, div_nxt;

    always_comb begin
        // Multiply: conditional add of the multiplicand, then shift right by one.
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : '0)};
        mul_nxt = {sum, lo[W-1:1]};

        // Divide: shift the next dividend bit into the partial remainder and
        // subtract when it fits; the result is always < divisor so W bits hold it.
        rem_sh  = {hi, lo[W-1]};
        ge      = (rem_sh >= {1'b0, opnd});
        rem_n   = ge ? (rem_sh[W-1:0] - opnd) : rem_sh[W-1:0];
        div_nxt = {rem_n, lo[W-2:0], ge};

        raw     = mode_q ? div_nxt : mul_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            mode_q <= 1'b0;
        end else if (start) begin
            hi     <= '0;
            lo     <= div_mode ? a : b;
            opnd   <= div_mode ? b : a;
            mode_q <= div_mode;
        end else if (step) begin
            {hi, lo} <= raw;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO onto the HI/LO register file.
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  EX-stage op in (op_valid/op/src_a/src_b/flush),
//                stall_req/busy, HI/LO write port, div_by_zero pulse
// MTHI/MTLO write combinationally in the accepting cycle. Mul/div run 32
// iterations in BUSY on operand magnitudes; the sign fix-up is applied while
// capturing the last iteration, and DONE presents the write for one cycle.
`timescale 1ns/1ps
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);

    state_t        state, state_nxt;
    logic [4:0]    cnt;
    logic [DW-1:0] hi_q, lo_q;
    logic          suppress, div_q, neg_q, rem_neg_q;

    logic          accept, sgn, sa, sb, op_div, b_zero, start, last;
    logic [DW-1:0] mag_a, mag_b;
    logic [2*DW-1:0] raw, prod_c;
    logic [DW-1:0] quo_c, rem_c, fin_hi, fin_lo;

    logic          stall_req, we_hi, we_lo, div_by_zero;
    logic [DW-1:0] wb_hi, wb_lo;

    // Gating with rst_n keeps every output low while reset is held.
    assign accept = bus.op_valid & ~bus.flush & rst_n;
    assign sgn    = ~bus.op[0];                 // MULT and DIV are the even codes
    assign sa     = sgn & bus.src_a[DW-1];
    assign sb     = sgn & bus.src_b[DW-1];
    // Two's-complement negate: 0x80000000 maps to itself, read as unsigned.
    assign mag_a  = sa ? -bus.src_a : bus.src_a;
    assign mag_b  = sb ? -bus.src_b : bus.src_b;
    assign op_div = is_div(bus.op);
    assign b_zero = (bus.src_b == '0);
    assign start  = (state == IDLE) & accept & is_muldiv(bus.op) & ~(op_div & b_zero);
    assign last   = (cnt == 5'd31);

    mdu_iter #(.W(DW)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .step     (state == BUSY),
        .div_mode (op_div),
        .a        (mag_a),
        .b        (mag_b),
        .raw      (raw)
    );

    // Sign correction: product/quotient negated when operand signs differ,
    // remainder follows the dividend's sign.
    always_comb begin
        prod_c = neg_q ? -raw : raw;
        quo_c  = neg_q ? -raw[DW-1:0] : raw[DW-1:0];
        rem_c  = rem_neg_q ? -raw[2*DW-1:DW] : raw[2*DW-1:DW];
        fin_hi = div_q ? rem_c : prod_c[2*DW-1:DW];
        fin_lo = div_q ? quo_c : prod_c[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            suppress  <= 1'b0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept && is_muldiv(bus.op)) begin
                        cnt       <= '0;
                        div_q     <= op_div;
                        neg_q     <= sa ^ sb;
                        rem_neg_q <= sa;
                        suppress  <= op_div & b_zero;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 5'd1;
                    if (last && !bus.flush) begin
                        hi_q <= fin_hi;
                        lo_q <= fin_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        stall_req   = 1'b0;
        we_hi       = 1'b0;
        we_lo       = 1'b0;
        wb_hi       = '0;
        wb_lo       = '0;
        div_by_zero = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_muldiv(bus.op)) begin
                        stall_req = 1'b1;
                        state_nxt = (op_div && b_zero) ? DONE : BUSY;
                    end else if (bus.op == OP_MTHI) begin
                        we_hi = 1'b1;
                        wb_hi = bus.src_a;
                    end else if (bus.op == OP_MTLO) begin
                        we_lo = 1'b1;
                        wb_lo = bus.src_a;
                    end
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall_req = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE: begin
                // op_valid is not looked at here, so the stalled op is not re-accepted.
                state_nxt = IDLE;
                wb_hi     = hi_q;
                wb_lo     = lo_q;
                if (!bus.flush) begin
                    if (suppress) begin
                        div_by_zero = 1'b1;
                    end else begin
                        we_hi = 1'b1;
                        we_lo = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.stall_req   = stall_req;
    assign bus.busy        = (state != IDLE);
    assign bus.we_hi       = we_hi;
    assign bus.we_lo       = we_lo;
    assign bus.wb_hi       = wb_hi;
    assign bus.wb_lo       = wb_lo;
    assign bus.div_by_zero = div_by_zero;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors with hand-computed HI/LO results, timing of
// stall/busy/write pulses, divide-by-zero, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mdu_if #(.W(DW)) bus();

    mdu_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = v;
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
    endtask

    // Issues a mul/div at T and walks it to T+34. If nxt_v, the next op is
    // presented from T+33 (DONE, must be ignored) and left applied at T+34.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit nxt_v, input logic [2:0] nxt_op,
                          input logic [31:0] nxt_a, input logic [31:0] nxt_b);
        int sc;
        drive(1'b1, o, a, b);
        bus.flush = 1'b0;
        #1;
        chk({tag, " stall@T"}, {31'b0, bus.stall_req}, 32'd1);
        cyc();
        bus.op_valid = 1'b0;
        sc = 0;
        for (int k = 0; k < 32; k++) begin
            #1;
            if (bus.stall_req && bus.busy && !bus.we_hi && !bus.we_lo) sc++;
            cyc();
        end
        if (nxt_v) drive(1'b1, nxt_op, nxt_a, nxt_b);
        #1;
        chk({tag, " stall T+1..32"}, sc, 32'd32);
        chk({tag, " stall@T+33"}, {31'b0, bus.stall_req}, 32'd0);
        chk({tag, " we_hi"}, {31'b0, bus.we_hi}, 32'd1);
        chk({tag, " we_lo"}, {31'b0, bus.we_lo}, 32'd1);
        chk({tag, " wb_hi"}, bus.wb_hi, exp_hi);
        chk({tag, " wb_lo"}, bus.wb_lo, exp_lo);
        cyc();
        if (!nxt_v) begin
            bus.op_valid = 1'b0;
            #1;
            chk({tag, " idle@T+34"}, {31'b0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {31'b0, bus.busy}, 32'd0);
        chk("rst stall", {31'b0, bus.stall_req}, 32'd0);
        chk("rst we", {30'b0, bus.we_hi, bus.we_lo}, 32'd0);
        chk("rst wb_hi", bus.wb_hi, 32'd0);
        chk("rst wb_lo", bus.wb_lo, 32'd0);
        chk("rst dbz", {31'b0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // MTHI / MTLO same-cycle writes, flush cancels
        drive(1'b1, OP_MTHI, 32'h1234, 32'h0);
        #1;
        chk("mthi we_hi", {31'b0, bus.we_hi}, 32'd1);
        chk("mthi wb_hi", bus.wb_hi, 32'h1234);
        chk("mthi we_lo", {31'b0, bus.we_lo}, 32'd0);
        chk("mthi stall", {31'b0, bus.stall_req}, 32'd0);
        bus.flush = 1'b1;
        #1;
        chk("mthi flush we_hi", {31'b0, bus.we_hi}, 32'd0);
        bus.flush = 1'b0;
        drive(1'b1, OP_MTLO, 32'hCAFE_0001, 32'h0);
        #1;
        chk("mtlo we", {30'b0, bus.we_hi, bus.we_lo}, 32'd1);
        chk("mtlo wb_lo", bus.wb_lo, 32'hCAFE_0001);
        drive(1'b1, 3'd6, 32'h5, 32'h5);
        #1;
        chk("op6 ignored", {29'b0, bus.stall_req, bus.we_hi, bus.we_lo}, 32'd0);
        cyc();
        chk("op6 idle", {31'b0, bus.busy}, 32'd0);

        // Chained: each next op offered during DONE, accepted at T+34
        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
               1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               1'b0, 3'd0, 32'd0, 32'd0);
        run_op("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3,
               1'b0, 3'd0, 32'd0, 32'd0);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
               1'b0, 3'd0, 32'd0, 32'd0);

        // Divide by zero
        drive(1'b1, OP_DIV, 32'd5, 32'd0);
        #1;
        chk("dbz stall@T", {31'b0, bus.stall_req}, 32'd1);
        cyc();
        bus.op_valid = 1'b0;
        #1;
        chk("dbz pulse", {31'b0, bus.div_by_zero}, 32'd1);
        chk("dbz we", {30'b0, bus.we_hi, bus.we_lo}, 32'd0);
        chk("dbz stall@T+1", {31'b0, bus.stall_req}, 32'd0);
        cyc();
        chk("dbz end", {30'b0, bus.div_by_zero, bus.busy}, 32'd0);

        // Flush at T+10
        drive(1'b1, OP_DIV, 32'd100, 32'd7);
        cyc();
        bus.op_valid = 1'b0;
        repeat (9) cyc();
        bus.flush = 1'b1;
        #1;
        chk("flush stall@T+10", {31'b0, bus.stall_req}, 32'd0);
        cyc();
        bus.flush = 1'b0;
        #1;
        chk("flush idle@T+11", {31'b0, bus.busy}, 32'd0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.we_hi || bus.we_lo || bus.div_by_zero || bus.busy) bad++;
            cyc();
        end
        chk("flush no write", bad, 32'd0);

        // Reset at T+5
        drive(1'b1, OP_DIV, 32'd100, 32'd7);
        cyc();
        bus.op_valid = 1'b0;
        repeat (4) cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst busy/stall", {30'b0, bus.busy, bus.stall_req}, 32'd0);
        chk("midrst we/dbz", {29'b0, bus.we_hi, bus.we_lo, bus.div_by_zero}, 32'd0);
        chk("midrst wb", bus.wb_hi | bus.wb_lo, 32'd0);
        cyc();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.we_hi || bus.we_lo || bus.div_by_zero || bus.busy) bad++;
            cyc();
        end
        chk("midrst no write", bad, 32'd0);

        run_op("divu after rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14,
               1'b0, 3'd0, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide controller that sequences every HI/LO-writing instruction (MULT, MULTU, DIV, DIVU, MTHI, MTLO) onto the HI/LO register file. It sits beside the EX stage. It runs 32-iteration shift-add multiplies and restoring divides, stalls the pipeline while it iterates, and drives the register file's write-enable and write-data ports. MFHI/MFLO read paths and forwarding are outside this block.

## Interface
- DW, 32, operand width; HI/LO are DW each, product is 2*DW.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX stage presents a HI/LO op this cycle.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 ignored.
- src_a  in  DW  rs value (multiplicand / dividend / MT source).
- src_b  in  DW  rt value (multiplier / divisor).
- flush  in  1  exception/branch cancel of the op in EX.
- stall_req  out  1  hold the pipeline.
- busy  out  1  state != IDLE.
- we_hi, we_lo  out  1  write enables to the HI/LO register file.
- wb_hi, wb_lo  out  DW  write data to the HI/LO register file.
- div_by_zero  out  1  one-cycle pulse on DIV/DIVU with src_b==0.

## Operation
- States: IDLE, BUSY, DONE. Reset values: IDLE, iteration counter 0, result registers 0. All outputs reset to 0.
- In IDLE with op_valid=1 and flush=0:
  - MTHI/MTLO: combinational same-cycle write. we_hi=1 with wb_hi=src_a, or we_lo=1 with wb_lo=src_a. No stall, state stays IDLE.
  - MUL/DIV: latch operand magnitudes and sign flags, then go to BUSY with counter=0. DIV/DIVU with src_b==0 goes directly to DONE with a write-suppress flag set.
- Signed ops operate on magnitudes: abs(0x80000000)=0x80000000 as unsigned.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if signs differ. The remainder takes the dividend's sign.
- BUSY: one iteration per cycle. After 32 iterations (counter==31 at the clock edge) go to DONE with final sign correction applied into the result registers.
- DONE: we_hi=we_lo=1. wb_lo = low product or quotient. wb_hi = high product or remainder. Exception: if write-suppress is set, both enables are 0 and div_by_zero=1. Next state is IDLE unconditionally. op_valid is ignored in DONE, so the same instruction is not re-accepted.
- stall_req = (IDLE & op_valid & ~flush & op∈{0..3}) | (BUSY & ~flush).
- flush in BUSY or DONE: next state IDLE. Same-cycle we_hi/we_lo/div_by_zero forced to 0. HI/LO are left untouched.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF wraps: quotient 0x80000000, remainder 0. No trap.

## Timing
- MUL/DIV accepted at cycle T:
  - BUSY during T+1..T+32.
  - DONE at T+33, writes happen that cycle and the register file latches them at the end of T+33.
  - stall_req is high T..T+32 and low at T+33.
- Divide by zero: accepted at T, DONE at T+1 with the div_by_zero pulse. stall_req is high at T only.
- MTHI/MTLO: zero latency, write in the accepting cycle.
- The next op can be accepted at T+34 (IDLE).
- Reset asserted mid-operation: immediate IDLE, all outputs 0, no partial write.

## Structure
- Package mdu_pkg holds:
  - op encodings (OP_MULT..OP_MTLO);
  - the state enum (IDLE/BUSY/DONE);
  - DW default;
  - the is_muldiv() helper.
- Sub-module mdu_iter holds the shared 64-bit accumulator datapath: a shift-add step for multiply and a subtract-restore step for divide, selected by a mode bit. Inputs are start and operands; output is the raw {hi,lo}.
- mdu_ctrl holds the FSM, the counter, sign correction and the register-file interface.

## Test plan
- MULT src_a=0xFFFFFFFE, src_b=3 → stall_req high T..T+32; at T+33 we_hi=we_lo=1, wb_hi=0xFFFFFFFF, wb_lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → wb_hi=0xFFFFFFFE, wb_lo=0x00000001. Back-to-back accept of the next op occurs at T+34, not at T+33.
- DIV 0xFFFFFFF9/2 → wb_lo=0xFFFFFFFD, wb_hi=0xFFFFFFFF. DIVU 7/2 → wb_lo=3, wb_hi=1. DIV 0x80000000/0xFFFFFFFF → wb_lo=0x80000000, wb_hi=0.
- DIV 5/0 → div_by_zero=1 at T+1, we_hi=we_lo=0, stall_req high only at T.
- DIV 100/7 with flush=1 at T+10 → stall_req low at T+10, IDLE at T+11, no we pulse. Same setup with rst_n low at T+5 → all outputs 0 immediately, no write.
- MTHI src_a=0x1234 in IDLE → same cycle we_hi=1, wb_hi=0x1234, we_lo=0, stall_req=0. The same op with flush=1 → no write.
